// File: rtl/attractor_detector.sv
// rtl/attractor_detector.sv - classifies a Boolean network trajectory as fixed point, limit cycle or timeout
// A repeat seen within MAX_PERIOD steps is confirmed over one full period before it is reported.
module attractor_detector #(
  parameter int STATE_W    = 9,
  parameter int MAX_PERIOD = 8,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 200
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              state_valid,
  input  logic [STATE_W-1:0]                net_state,
  output logic                              busy,
  output logic                              done,
  output logic                              fixed_point,
  output logic                              cycle_found,
  output logic                              timed_out,
  output logic [$clog2(MAX_PERIOD+1)-1:0]   period,
  output logic [CNT_W-1:0]                  transient_len,
  output logic [STATE_W-1:0]                attractor_state
);
  localparam int PW = $clog2(MAX_PERIOD + 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONFIRM, DONE} state_e;

  state_e              fsm_q, fsm_d;
  logic [STATE_W-1:0]  hist_q [MAX_PERIOD];
  logic [STATE_W-1:0]  hist_d [MAX_PERIOD];
  logic [MAX_PERIOD-1:0] hv_q, hv_d;
  logic [CNT_W-1:0]    n_q, n_d, first_idx_q, first_idx_d, tl_q, tl_d;
  logic [PW-1:0]       conf_q, conf_d, k_q, k_d, period_q, period_d;
  logic [STATE_W-1:0]  first_state_q, first_state_d, as_q, as_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                fp_q, fp_d, cf_q, cf_d, to_q, to_d;

  logic                hit;
  logic [PW-1:0]       hit_k;
  logic [STATE_W-1:0]  cmp_state;
  logic                last_sample;

  // Descending scan so the smallest matching lag wins.
  always_comb begin
    hit       = 1'b0;
    hit_k     = '0;
    cmp_state = '0;
    for (int i = MAX_PERIOD - 1; i >= 0; i--) begin
      if (hv_q[i] && hist_q[i] == net_state) begin
        hit   = 1'b1;
        hit_k = PW'(i + 1);
      end
      if (PW'(i + 1) == k_q) cmp_state = hist_q[i];
    end
  end

  assign last_sample = (n_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    fsm_d         = fsm_q;
    hist_d        = hist_q;
    hv_d          = hv_q;
    n_d           = n_q;
    conf_d        = conf_q;
    k_d           = k_q;
    first_idx_d   = first_idx_q;
    first_state_d = first_state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    fp_d          = fp_q;
    cf_d          = cf_q;
    to_d          = to_q;
    period_d      = period_q;
    tl_d          = tl_q;
    as_d          = as_q;
    if ((fsm_q == SAMPLE || fsm_q == CONFIRM) && state_valid) begin
      hist_d[0] = net_state;
      hv_d[0]   = 1'b1;
      for (int i = 1; i < MAX_PERIOD; i++) begin
        hist_d[i] = hist_q[i-1];
        hv_d[i]   = hv_q[i-1];
      end
      n_d = n_q + CNT_W'(1);
    end
    case (fsm_q)
      IDLE, DONE: begin
        if (start) begin
          fsm_d    = SAMPLE;
          hv_d     = '0;
          n_d      = '0;
          conf_d   = '0;
          busy_d   = 1'b1;
          fp_d     = 1'b0;
          cf_d     = 1'b0;
          to_d     = 1'b0;
          period_d = '0;
          tl_d     = '0;
          as_d     = '0;
        end
      end
      SAMPLE: begin
        if (state_valid) begin
          if (last_sample) begin
            fsm_d  = DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
            to_d   = 1'b1;
          end else if (hit) begin
            fsm_d         = CONFIRM;
            k_d           = hit_k;
            first_idx_d   = n_q - CNT_W'(hit_k);
            first_state_d = net_state;
            conf_d        = '0;
          end
        end
      end
      CONFIRM: begin
        if (state_valid) begin
          // A confirmation completing on the final sample beats the timeout.
          if (net_state == cmp_state && conf_q + PW'(1) == k_q) begin
            fsm_d    = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            period_d = k_q;
            fp_d     = (k_q == PW'(1));
            cf_d     = (k_q != PW'(1));
            tl_d     = first_idx_q;
            as_d     = first_state_q;
          end else if (last_sample) begin
            fsm_d  = DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
            to_d   = 1'b1;
          end else if (net_state == cmp_state) begin
            conf_d = conf_q + PW'(1);
          end else begin
            fsm_d = SAMPLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= IDLE;
      hist_q        <= '{default: '0};
      hv_q          <= '0;
      n_q           <= '0;
      conf_q        <= '0;
      k_q           <= '0;
      first_idx_q   <= '0;
      first_state_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fp_q          <= 1'b0;
      cf_q          <= 1'b0;
      to_q          <= 1'b0;
      period_q      <= '0;
      tl_q          <= '0;
      as_q          <= '0;
    end else begin
      fsm_q         <= fsm_d;
      hist_q        <= hist_d;
      hv_q          <= hv_d;
      n_q           <= n_d;
      conf_q        <= conf_d;
      k_q           <= k_d;
      first_idx_q   <= first_idx_d;
      first_state_q <= first_state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fp_q          <= fp_d;
      cf_q          <= cf_d;
      to_q          <= to_d;
      period_q      <= period_d;
      tl_q          <= tl_d;
      as_q          <= as_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign fixed_point     = fp_q;
  assign cycle_found     = cf_q;
  assign timed_out       = to_q;
  assign period          = period_q;
  assign transient_len   = tl_q;
  assign attractor_state = as_q;
endmodule

// File: doc/attractor_detector.md
Name: attractor_detector

Overview:
- Observer that consumes the state vector stream of a synchronous Boolean network model, one sample per valid cycle.
- Classifies the trajectory as a fixed point (steady state), a limit cycle of period 2..MAX_PERIOD, or timeout.
- Reports the period, the transient length and the attractor entry state.
- Sits downstream of the network core, where the testbench or host reads results after `start`.

Parameters:
- STATE_W, 9, width of the network state vector.
- MAX_PERIOD, 8, longest detectable cycle period and depth of the history buffer (>=1).
- CNT_W, 8, width of the sample, transient and timeout counters.
- TIMEOUT, 200, number of valid samples after `start` before giving up (1..2^CNT_W-1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new classification; honoured in IDLE/DONE only
- state_valid  in  1  net_state carries a new network step this cycle
- net_state  in  STATE_W  current network state vector
- busy  out  1  high in SAMPLE/CONFIRM
- done  out  1  one-cycle pulse when a result is final
- fixed_point  out  1  result: period == 1
- cycle_found  out  1  result: confirmed attractor of period 2..MAX_PERIOD
- timed_out  out  1  result: no confirmed attractor within TIMEOUT samples
- period  out  $clog2(MAX_PERIOD+1)  detected period, 0 if timed_out
- transient_len  out  CNT_W  index of the first occurrence of the attractor entry state
- attractor_state  out  STATE_W  state at that first occurrence

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs 0. History valid bits cleared, all counters 0.
- FSM states: IDLE, SAMPLE, CONFIRM, DONE. All outputs are registered.
- IDLE/DONE with start=1:
  - Clear history valid bits, sample index n, confirm count, and all result outputs.
  - Go to SAMPLE next cycle.
  - A state_valid asserted in the same cycle as start is not captured.
- start while busy: ignored.
- History: shift register hist[0..MAX_PERIOD-1] with valid bits. Each valid sample shifts in, so hist[0] is the previous sample. The shift occurs in both SAMPLE and CONFIRM.
- n increments on every valid sample in SAMPLE/CONFIRM. Cycles without state_valid freeze all counters and the FSM.
- SAMPLE, on a valid sample:
  - Find the smallest k in 1..MAX_PERIOD with hist[k-1] valid and equal to net_state.
  - If found: latch k, latch first_idx = n-k and first_state = net_state, set conf=0, go to CONFIRM.
- CONFIRM, on a valid sample:
  - If net_state == hist[k-1]: conf++. When conf reaches k, the match is confirmed:
    - Go to DONE and pulse done.
    - period = k; fixed_point = (k==1); cycle_found = (k>1).
    - transient_len = first_idx; attractor_state = first_state.
  - On a mismatch: return to SAMPLE. History is retained, and the same sample is not re-searched in that cycle.
- Timeout: if the valid sample that makes n+1 == TIMEOUT does not complete a confirmation, go to DONE with timed_out=1, pulse done, period=0.
  - If confirmation completes on that same sample, success wins.
- DONE: results held until the next start. done is high exactly one cycle, on DONE entry.
- Result flags are mutually exclusive: exactly one of fixed_point / cycle_found / timed_out is 1 while in DONE.
- Periods above MAX_PERIOD are never matched and end in timeout.
- Reset mid-operation aborts immediately with no done pulse.
- Latency: done asserts the cycle after the confirming valid sample.

Test Plan:
1. start, then valid samples A,A,A (A=9'h0A5) -> done after the 3rd sample; fixed_point=1, period=1, transient_len=0, attractor_state=9'h0A5.
2. start, then X,Y,A,A,A -> done after the 5th sample; fixed_point=1, transient_len=2, attractor_state=A.
3. start, then B,C,D repeated for 7 samples -> done after sample index 6; cycle_found=1, period=3, transient_len=0, attractor_state=B.
4. start, then A,A,B,C,D,E,F,... all distinct with TIMEOUT=20 -> CONFIRM entered at index 1, mismatch at index 2 returns to SAMPLE; done after the 20th sample; timed_out=1, period=0.
5. start, then period-9 sequence with MAX_PERIOD=8, TIMEOUT=30 -> timed_out=1 after 30 samples. Then state_valid gaps of 3 cycles between samples -> identical result, only the done cycle shifts.
6. rst_n pulsed low mid-CONFIRM in scenario 3 -> all outputs 0 asynchronously, no done pulse. A fresh start then reproduces scenario 3; start asserted while busy has no effect.
